// File: rtl/mux_switch_sequencer_if.sv
// Command side (LA strobe/select/flags, forced resets) and mux control side of the
// switch sequencer, bundled so the sequencer and its driver share one connection.
interface mux_switch_sequencer_if;
    logic       i_cmd_strobe;
    logic [3:0] i_cmd_sel;
    logic [2:0] i_cmd_flags;
    logic [7:0] i_force_reset;
    logic       mux_conf_clk;
    logic [3:0] o_mux_sel;
    logic       o_mux_sys_reset_enb;
    logic       o_mux_io5_reset_enb;
    logic       o_mux_auto_reset_enb;
    logic [7:0] o_design_reset;
    logic       o_busy;
    logic       o_cmd_dropped;
    logic [3:0] o_cur_sel;

    modport slave (
        input  i_cmd_strobe, i_cmd_sel, i_cmd_flags, i_force_reset,
        output mux_conf_clk, o_mux_sel, o_mux_sys_reset_enb, o_mux_io5_reset_enb,
               o_mux_auto_reset_enb, o_design_reset, o_busy, o_cmd_dropped, o_cur_sel
    );

    modport master (
        output i_cmd_strobe, i_cmd_sel, i_cmd_flags, i_force_reset,
        input  mux_conf_clk, o_mux_sel, o_mux_sys_reset_enb, o_mux_io5_reset_enb,
               o_mux_auto_reset_enb, o_design_reset, o_busy, o_cmd_dropped, o_cur_sel
    );
endinterface

// File: rtl/mux_switch_sequencer.sv
// Turns one LA strobe into a glitch-safe design-mux switchover: hold resets, clock the
// new select/flags into the mux with a generated conf clock, hold, then release.
module mux_switch_sequencer #(
    parameter int unsigned RST_PRE     = 4,
    parameter int unsigned CONF_HALF   = 2,
    parameter int unsigned CONF_PULSES = 3,
    parameter int unsigned RST_POST    = 4,
    parameter logic [3:0]  RESET_SEL   = 4'hF
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    mux_switch_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, PRE, CONF_LO, CONF_HI, POST} state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] pulse_q, pulse_d;
    logic       conf_clk_q, conf_clk_d;
    logic [3:0] mux_sel_q, mux_sel_d;
    logic [2:0] enb_q, enb_d;
    logic [3:0] cur_sel_q, cur_sel_d;
    logic [3:0] cap_sel_q, cap_sel_d;
    logic [2:0] cap_flags_q, cap_flags_d;
    logic       hold_q, hold_d;
    logic       busy_q, busy_d;
    logic       dropped_q, dropped_d;
    logic [2:0] sync_q;
    logic       strobe_rise;
    logic [3:0] pulse_inc;

    // sync_q[1] is the synchronized strobe; sync_q[2] is its previous value
    assign strobe_rise = sync_q[1] & ~sync_q[2];
    assign pulse_inc   = pulse_q + 4'd1;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pulse_q     <= '0;
            conf_clk_q  <= 1'b0;
            mux_sel_q   <= RESET_SEL;
            enb_q       <= '1;
            cur_sel_q   <= RESET_SEL;
            cap_sel_q   <= RESET_SEL;
            cap_flags_q <= '1;
            hold_q      <= 1'b0;
            busy_q      <= 1'b0;
            dropped_q   <= 1'b0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
            conf_clk_q  <= conf_clk_d;
            mux_sel_q   <= mux_sel_d;
            enb_q       <= enb_d;
            cur_sel_q   <= cur_sel_d;
            cap_sel_q   <= cap_sel_d;
            cap_flags_q <= cap_flags_d;
            hold_q      <= hold_d;
            busy_q      <= busy_d;
            dropped_q   <= dropped_d;
            sync_q      <= {sync_q[1:0], bus.i_cmd_strobe};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_d     = pulse_q;
        conf_clk_d  = conf_clk_q;
        mux_sel_d   = mux_sel_q;
        enb_d       = enb_q;
        cur_sel_d   = cur_sel_q;
        cap_sel_d   = cap_sel_q;
        cap_flags_d = cap_flags_q;
        hold_d      = hold_q;
        busy_d      = busy_q;
        dropped_d   = dropped_q;

        if (strobe_rise && state_q != IDLE) dropped_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (strobe_rise) begin
                    state_d     = PRE;
                    cnt_d       = '0;
                    cap_sel_d   = bus.i_cmd_sel;
                    cap_flags_d = bus.i_cmd_flags;
                    hold_d      = 1'b1;
                    busy_d      = 1'b1;
                    dropped_d   = 1'b0;
                end
            end
            PRE: begin
                if (cnt_q == 8'(RST_PRE - 1)) begin
                    // select/flags change on CONF_LO entry so they lead the first rising edge
                    state_d   = CONF_LO;
                    cnt_d     = '0;
                    pulse_d   = '0;
                    mux_sel_d = cap_sel_q;
                    enb_d     = cap_flags_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CONF_LO: begin
                if (cnt_q == 8'(CONF_HALF - 1)) begin
                    state_d    = CONF_HI;
                    cnt_d      = '0;
                    conf_clk_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CONF_HI: begin
                if (cnt_q == 8'(CONF_HALF - 1)) begin
                    cnt_d      = '0;
                    pulse_d    = pulse_inc;
                    conf_clk_d = 1'b0;
                    state_d    = (pulse_inc < 4'(CONF_PULSES)) ? CONF_LO : POST;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            POST: begin
                if (cnt_q == 8'(RST_POST - 1)) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    hold_d    = 1'b0;
                    busy_d    = 1'b0;
                    cur_sel_d = cap_sel_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mux_conf_clk         = conf_clk_q;
    assign bus.o_mux_sel            = mux_sel_q;
    assign bus.o_mux_sys_reset_enb  = enb_q[2];
    assign bus.o_mux_io5_reset_enb  = enb_q[1];
    assign bus.o_mux_auto_reset_enb = enb_q[0];
    assign bus.o_design_reset       = {8{hold_q}} | bus.i_force_reset;
    assign bus.o_busy               = busy_q;
    assign bus.o_cmd_dropped        = dropped_q;
    assign bus.o_cur_sel            = cur_sel_q;

endmodule

// File: tb/tb_mux_switch_sequencer.sv
// Bench for mux_switch_sequencer: table of switch commands scored through a queue,
// plus hand sequences for reset abort and a held strobe.
module tb_mux_switch_sequencer;

    logic clk;
    logic rst;

    mux_switch_sequencer_if bus();

    mux_switch_sequencer dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the mux's 2-deep capture on mux_conf_clk
    logic [6:0] cap1, cap2;
    initial begin
        cap1 = '0;
        cap2 = '0;
    end
    always @(posedge bus.mux_conf_clk) begin
        cap1 <= {bus.o_mux_sel, bus.o_mux_sys_reset_enb, bus.o_mux_io5_reset_enb,
                 bus.o_mux_auto_reset_enb};
        cap2 <= cap1;
    end

    typedef struct {
        logic [3:0] sel;
        logic [2:0] flags;
        logic [7:0] frc;
        int         inject_at;
        int         exp_busy;
        int         exp_pulses;
        int         exp_hi;
        logic [3:0] exp_cur;
        logic       exp_dropped;
    } vec_t;

    vec_t vecs[5];
    vec_t sb_q[$];

    int n_vec;
    int n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] sel, input logic [2:0] flags, input logic [7:0] frc);
        @(negedge clk);
        bus.i_cmd_sel     = sel;
        bus.i_cmd_flags   = flags;
        bus.i_force_reset = frc;
        @(negedge clk);
        check("idle_force", 32'(bus.o_design_reset), 32'(frc));
        bus.i_cmd_strobe = 1'b1;
        @(negedge clk);
        bus.i_cmd_strobe = 1'b0;
    endtask

    // Watches one sequence from before busy rises until it falls, then scores it.
    task automatic observe(input int inject_at);
        vec_t e;
        int   busy_cnt, rises, hi, hi_min, hi_max, stable, setup, rst_bad;
        logic seen, done, prev;
        busy_cnt = 0; rises = 0; hi = 0; hi_min = 999; hi_max = 0;
        stable = 0; setup = -1; rst_bad = 0; seen = 0; done = 0; prev = 0;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            return;
        end
        e = sb_q.pop_front();
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (bus.o_busy) begin
                seen = 1;
                busy_cnt++;
                if (bus.o_design_reset !== 8'hFF) rst_bad++;
                if (inject_at > 0 && busy_cnt == inject_at) begin
                    bus.i_cmd_sel    = 4'h7;
                    bus.i_cmd_strobe = 1'b1;
                end
                if (inject_at > 0 && busy_cnt == inject_at + 1) bus.i_cmd_strobe = 1'b0;
            end else if (seen) begin
                done = 1;
            end
            if (bus.mux_conf_clk && !prev) begin
                rises++;
                if (rises == 1) setup = stable;
            end
            if (bus.mux_conf_clk) hi++;
            else if (prev) begin
                if (hi < hi_min) hi_min = hi;
                if (hi > hi_max) hi_max = hi;
                hi = 0;
            end
            if ({bus.o_mux_sel, bus.o_mux_sys_reset_enb, bus.o_mux_io5_reset_enb,
                 bus.o_mux_auto_reset_enb} == {e.sel, e.flags}) stable++;
            else stable = 0;
            prev = bus.mux_conf_clk;
        end
        check("seq_done", 32'(done), 1);
        check("busy_cycles", busy_cnt, e.exp_busy);
        check("conf_pulses", rises, e.exp_pulses);
        check("conf_hi_min", hi_min, e.exp_hi);
        check("conf_hi_max", hi_max, e.exp_hi);
        check("sel_setup_ok", 32'(setup >= e.exp_hi), 1);
        check("reset_held", rst_bad, 0);
        check("cur_sel", 32'(bus.o_cur_sel), 32'(e.exp_cur));
        check("mux_capture", 32'(cap2), 32'({e.sel, e.flags}));
        check("design_reset_after", 32'(bus.o_design_reset), 32'(e.frc));
        check("cmd_dropped", 32'(bus.o_cmd_dropped), 32'(e.exp_dropped));
    endtask

    initial begin
        int   rises, busy_rises;
        logic prev, prev_busy;
        n_vec = 0;
        n_bad = 0;

        vecs[0] = '{4'h2, 3'b010, 8'h00, 0, 20, 3, 2, 4'h2, 1'b0};
        vecs[1] = '{4'h5, 3'b101, 8'h08, 0, 20, 3, 2, 4'h5, 1'b0};
        vecs[2] = '{4'h5, 3'b111, 8'h00, 0, 20, 3, 2, 4'h5, 1'b0};
        vecs[3] = '{4'h9, 3'b100, 8'h81, 5, 20, 3, 2, 4'h9, 1'b1};
        vecs[4] = '{4'h0, 3'b000, 8'h00, 0, 20, 3, 2, 4'h0, 1'b0};

        rst = 1'b1;
        bus.i_cmd_strobe  = 1'b0;
        bus.i_cmd_sel     = 4'h0;
        bus.i_cmd_flags   = 3'b000;
        bus.i_force_reset = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state, and no conf pulses while idle
        @(negedge clk);
        check("rst_mux_sel", 32'(bus.o_mux_sel), 32'hF);
        check("rst_cur_sel", 32'(bus.o_cur_sel), 32'hF);
        check("rst_enb", 32'({bus.o_mux_sys_reset_enb, bus.o_mux_io5_reset_enb,
                              bus.o_mux_auto_reset_enb}), 32'h7);
        check("rst_design_reset", 32'(bus.o_design_reset), 0);
        check("rst_busy", 32'(bus.o_busy), 0);
        check("rst_dropped", 32'(bus.o_cmd_dropped), 0);
        rises = 0;
        prev  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.mux_conf_clk && !prev) rises++;
            prev = bus.mux_conf_clk;
        end
        check("idle_no_pulse", rises, 0);

        foreach (vecs[i]) begin
            issue(vecs[i].sel, vecs[i].flags, vecs[i].frc);
            sb_q.push_back(vecs[i]);
            observe(vecs[i].inject_at);
        end

        // Reset during CONF_HI after the second pulse aborts the switch
        issue(4'h6, 3'b001, 8'h20);
        rises = 0;
        prev  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.mux_conf_clk && !prev) rises++;
            prev = bus.mux_conf_clk;
            if (rises == 2 && bus.mux_conf_clk) break;
        end
        check("abort_reached_pulse2", rises, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_conf_clk", 32'(bus.mux_conf_clk), 0);
        check("abort_mux_sel", 32'(bus.o_mux_sel), 32'hF);
        check("abort_cur_sel", 32'(bus.o_cur_sel), 32'hF);
        check("abort_busy", 32'(bus.o_busy), 0);
        check("abort_design_reset", 32'(bus.o_design_reset), 32'h20);
        rises = 0;
        prev  = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.mux_conf_clk && !prev) rises++;
            prev = bus.mux_conf_clk;
        end
        check("abort_no_more_pulses", rises, 0);
        bus.i_force_reset = 8'h00;

        // Strobe held high for 100 cycles gives exactly one sequence
        @(negedge clk);
        bus.i_cmd_sel    = 4'h3;
        bus.i_cmd_flags  = 3'b110;
        @(negedge clk);
        bus.i_cmd_strobe = 1'b1;
        busy_rises = 0;
        prev_busy  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.o_busy && !prev_busy) busy_rises++;
            prev_busy = bus.o_busy;
        end
        check("held_one_seq", busy_rises, 1);
        check("held_cur_sel", 32'(bus.o_cur_sel), 32'h3);
        bus.i_cmd_strobe = 1'b0;
        bus.i_cmd_sel    = 4'hA;
        bus.i_cmd_flags  = 3'b001;
        repeat (2) @(negedge clk);
        bus.i_cmd_strobe = 1'b1;
        sb_q.push_back('{4'hA, 3'b001, 8'h00, 0, 20, 3, 2, 4'hA, 1'b0});
        observe(0);
        bus.i_cmd_strobe = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
